// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adder_pkg
//  Description : Shared definitions for the bit-serial adder.
//                It holds the FSM state encoding and the default operand width.
//  Contents    : ADDER_W - default operand/result width
//                state_t - IDLE / RUN / DONE encoding
//  Revision    : 1.0  initial release
// ============================================================================
package adder_pkg;

    localparam int ADDER_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : adder_pkg
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
//  Module      : full_adder
//  Description : Single-bit full adder. It is the bit-slice datapath of the
//                serial adder.
//  Ports       : i_a, i_b  - operand bits
//                i_cin     - carry in
//                o_s       - sum bit
//                o_c       - carry out
//  Revision    : 1.0  initial release
// ============================================================================
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_c
);

    logic w_p;

    // Propagate term shared by the sum and the carry.
    assign w_p = i_a ^ i_b;
    assign o_s = w_p ^ i_cin;
    assign o_c = (i_a & i_b) | (i_cin & w_p);

endmodule : full_adder
`default_nettype wire

// File: rtl/bit_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : bit_serial_adder
//  Description : WIDTH-bit adder that processes one bit per clock, LSB first.
//                It uses one full_adder slice and holds the carry in a flop
//                between cycles. Operands arrive over a valid/ready handshake,
//                and the result leaves over a second valid/ready handshake.
//  Ports       : i_clk        - clock, rising edge
//                i_rst_n      - synchronous active-low reset
//                i_in_valid   - operand pair on i_a/i_b/i_cin is valid
//                o_in_ready   - block can accept operands (IDLE only)
//                i_a, i_b     - operands, sampled on the input handshake
//                i_cin        - carry-in, sampled on the input handshake
//                o_out_valid  - o_sum/o_cout hold a completed result
//                i_out_ready  - consumer accepts the result
//                o_sum        - registered result bits
//                o_cout       - registered carry-out of the MSB
//                o_busy       - high in RUN or DONE
//  Revision    : 1.0  initial release
// ============================================================================
module bit_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_busy
);

    // The counter must hold WIDTH itself, because it increments on the last RUN edge.
    localparam int               c_CNT_W    = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

    state_t              r_state;
    logic [WIDTH-1:0]    r_sh_a;
    logic [WIDTH-1:0]    r_sh_b;
    logic                r_carry;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [WIDTH-1:0]    r_sum;
    logic                r_cout;
    logic                r_in_ready;
    logic                r_out_valid;
    logic                r_busy;

    logic                w_s;
    logic                w_c;
    logic [WIDTH-1:0]    w_sum_next;

    full_adder u_fa (
        .i_a   (r_sh_a[0]),
        .i_b   (r_sh_b[0]),
        .i_cin (r_carry),
        .o_s   (w_s),
        .o_c   (w_c)
    );

    // Each new sum bit enters at the MSB. After WIDTH shifts, the first
    // (LSB) bit has reached position 0.
    if (WIDTH == 1) begin : g_sum_w1
        assign w_sum_next = w_s;
    end else begin : g_sum_wn
        assign w_sum_next = {w_s, r_sum[WIDTH-1:1]};
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_sh_a      <= '0;
            r_sh_b      <= '0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_in_valid && r_in_ready) begin
                        r_sh_a     <= i_a;
                        r_sh_b     <= i_b;
                        r_carry    <= i_cin;
                        r_cnt      <= '0;
                        r_sum      <= '0;
                        r_state    <= ST_RUN;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end

                ST_RUN: begin
                    r_sum   <= w_sum_next;
                    r_carry <= w_c;
                    r_sh_a  <= r_sh_a >> 1;
                    r_sh_b  <= r_sh_b >> 1;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == c_CNT_LAST) begin
                        r_cout      <= w_c;
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                    end
                end

                ST_DONE: begin
                    // The result stays stable here. New operands are not
                    // accepted until the consumer takes the result.
                    if (i_out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_sum       = r_sum;
    assign o_cout      = r_cout;
    assign o_busy      = r_busy;

endmodule : bit_serial_adder
`default_nettype wire

// File: tb/tb_bit_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bit_serial_adder
//  Description : Self-checking bench for bit_serial_adder. An 8-bit instance
//                runs directed scenarios followed by random traffic. A 1-bit
//                instance runs exhaustive traffic and a 16-bit instance runs
//                random traffic. The expected sums A+B+CIN are queued when an
//                operand pair is accepted. A monitor per instance pops the
//                queue and compares on each output handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bit_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: wait bound expired, expected DUT response never came (t=%0t)", nm, $time);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // 8-bit instance: directed and random
    // ------------------------------------------------------------------
    logic       rst_n, in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
    logic [7:0] a, b, sum;
    logic       or_dir, or_rnd, rand_mode;
    logic [8:0] q8[$];

    assign out_ready = rand_mode ? or_rnd : or_dir;

    bit_serial_adder #(.WIDTH(8)) u_dut8 (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_a         (a),
        .i_b         (b),
        .i_cin       (cin),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_sum       (sum),
        .o_cout      (cout),
        .o_busy      (busy)
    );

    initial begin
        or_rnd = 1'b1;
        forever begin
            @(negedge clk);
            or_rnd = ($urandom_range(0, 3) != 0);
        end
    end

    // Inputs change on the falling edge, so sample 1 time unit after it.
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
                if (q8.size() == 0) begin
                    check("w8_unexpected_result", 32'({cout, sum}), 32'h1ff_dead);
                end else begin
                    e = q8.pop_front();
                    check("w8_result", 32'({cout, sum}), 32'(e));
                end
            end
        end
    end

    // This task is called just after a falling edge. If in_ready is already
    // high, the handshake happens at the next rising edge. The task returns
    // at the falling edge after the accept, with acc = index of the accept edge.
    task automatic send8(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                         input bit push, input bit hold, output int acc);
        a = ia; b = ib; cin = ic; in_valid = 1'b1;
        acc = -1;
        for (int t = 0; t < 200; t++) begin
            if (in_ready) begin
                if (push) q8.push_back(9'(ia) + 9'(ib) + 9'(ic));
                @(negedge clk);
                acc = cyc;
                break;
            end
            @(negedge clk);
        end
        if (!hold) in_valid = 1'b0;
        if (acc < 0) fail_now("w8_send");
    endtask

    task automatic wait_out8(output int c);
        c = -1;
        for (int t = 0; t < 100; t++) begin
            if (out_valid) begin
                c = cyc;
                break;
            end
            @(negedge clk);
        end
        if (c < 0) fail_now("w8_wait_out_valid");
    endtask

    task automatic wait_idle8();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 100; t++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) fail_now("w8_wait_idle");
    endtask

    // ------------------------------------------------------------------
    // 1-bit (exhaustive) and 16-bit (random) instances
    // ------------------------------------------------------------------
    for (genvar j = 0; j < 2; j++) begin : g_rnd
        localparam int W   = (j == 0) ? 1 : 16;
        localparam bit EXH = (W == 1);

        logic         g_rst_n, g_in_valid, g_in_ready, g_cin, g_out_valid, g_out_ready, g_cout, g_busy;
        logic [W-1:0] g_a, g_b, g_sum;
        logic [W:0]   q[$];
        bit           done = 1'b0;

        bit_serial_adder #(.WIDTH(W)) u_dut (
            .i_clk       (clk),
            .i_rst_n     (g_rst_n),
            .i_in_valid  (g_in_valid),
            .o_in_ready  (g_in_ready),
            .i_a         (g_a),
            .i_b         (g_b),
            .i_cin       (g_cin),
            .o_out_valid (g_out_valid),
            .i_out_ready (g_out_ready),
            .o_sum       (g_sum),
            .o_cout      (g_cout),
            .o_busy      (g_busy)
        );

        initial begin
            g_out_ready = 1'b1;
            forever begin
                @(negedge clk);
                g_out_ready = ($urandom_range(0, 2) != 0);
            end
        end

        initial begin
            logic [W:0] e;
            forever begin
                @(negedge clk);
                #1;
                if (g_rst_n === 1'b1 && g_out_valid === 1'b1 && g_out_ready === 1'b1) begin
                    if (q.size() == 0) begin
                        check($sformatf("w%0d_unexpected_result", W), 32'({g_cout, g_sum}), 32'h1ff_dead);
                    end else begin
                        e = q.pop_front();
                        check($sformatf("w%0d_result", W), 32'({g_cout, g_sum}), 32'(e));
                    end
                end
            end
        end

        initial begin
            int           acc;
            int           nops;
            logic [W-1:0] ra, rb;
            logic         rc;
            g_rst_n = 1'b0; g_in_valid = 1'b0; g_a = '0; g_b = '0; g_cin = 1'b0;
            repeat (3) @(negedge clk);
            g_rst_n = 1'b1;
            @(negedge clk);
            nops = EXH ? 64 : 300;
            for (int i = 0; i < nops; i++) begin
                if (EXH) begin
                    ra = W'(i); rb = W'(i >> 1); rc = 1'(i >> 2);
                end else begin
                    ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
                end
                g_a = ra; g_b = rb; g_cin = rc; g_in_valid = 1'b1;
                acc = -1;
                for (int t = 0; t < 200; t++) begin
                    if (g_in_ready) begin
                        q.push_back((W+1)'(ra) + (W+1)'(rb) + (W+1)'(rc));
                        @(negedge clk);
                        acc = cyc;
                        break;
                    end
                    @(negedge clk);
                end
                g_in_valid = 1'b0;
                if (acc < 0) fail_now($sformatf("w%0d_send", W));
            end
            for (int t = 0; t < 500 && q.size() != 0; t++) @(negedge clk);
            if (q.size() != 0) fail_now($sformatf("w%0d_drain", W));
            done = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Main sequence for the 8-bit instance
    // ------------------------------------------------------------------
    initial begin
        int  acc, acc2, tv;
        bit  seen;
        bit  both_done;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
        or_dir = 1'b1; rand_mode = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_sum",       32'(sum),       32'd0);
        check("rst_cout",      32'(cout),      32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic add and latency
        send8(8'h35, 8'h4A, 1'b0, 1'b1, 1'b0, acc);
        check("t1_busy",     32'(busy),     32'd1);
        check("t1_in_ready", 32'(in_ready), 32'd0);
        wait_out8(tv);
        check("t1_latency", 32'(tv - acc), 32'd8);
        wait_idle8();

        // Carry propagation through all bits
        send8(8'hFF, 8'h01, 1'b0, 1'b1, 1'b0, acc);
        send8(8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0, acc);
        wait_idle8();

        // Output stall: result held, inputs ignored
        or_dir = 1'b0;
        send8(8'h80, 8'h80, 1'b0, 1'b1, 1'b0, acc);
        wait_out8(tv);
        for (int i = 0; i < 5; i++) begin
            a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); in_valid = 1'b1;
            @(negedge clk);
            check("t3_in_ready",  32'(in_ready),      32'd0);
            check("t3_out_valid", 32'(out_valid),     32'd1);
            check("t3_held",      32'({cout, sum}),   32'h100);
        end
        in_valid = 1'b0;
        or_dir = 1'b1;
        wait_idle8();

        // Reset in the middle of RUN aborts the operation
        send8(8'hAA, 8'h55, 1'b1, 1'b0, 1'b0, acc);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t4_in_ready",  32'(in_ready),  32'd1);
        check("t4_out_valid", 32'(out_valid), 32'd0);
        check("t4_sum",       32'(sum),       32'd0);
        check("t4_busy",      32'(busy),      32'd0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) seen = 1'b1;
            @(negedge clk);
        end
        check("t4_no_valid_after_abort", 32'(seen), 32'd0);
        send8(8'h01, 8'h02, 1'b0, 1'b1, 1'b0, acc);
        wait_idle8();

        // Back-to-back accepts with IN_VALID held high
        send8(8'h12, 8'h34, 1'b1, 1'b1, 1'b1, acc);
        send8(8'h56, 8'h78, 1'b0, 1'b1, 1'b0, acc2);
        check("t5_spacing", 32'(acc2 - acc), 32'd10);
        wait_idle8();

        // Random traffic with output stalls
        rand_mode = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            send8(8'($urandom), 8'($urandom), 1'($urandom), 1'b1, 1'b0, acc);
        end
        for (int t = 0; t < 500 && q8.size() != 0; t++) @(negedge clk);
        if (q8.size() != 0) fail_now("w8_drain");
        @(negedge clk);
        rand_mode = 1'b0;

        both_done = 1'b0;
        for (int t = 0; t < 60000; t++) begin
            if (g_rnd[0].done && g_rnd[1].done) begin
                both_done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!both_done) fail_now("wide_narrow_runs_complete");
        check("q8_empty", 32'(q8.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_bit_serial_adder
`default_nettype wire
